// File: rtl/uart_cmd_framer.sv
// UART command framer: assembles HEADER/class/~class frames into
// a single validated class command with a valid/ready handshake.
module uart_cmd_framer #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         NUM_CLASSES = 4,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ack,
    input  logic [7:0]       RxData,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [1:0]       cmd_class,
    output logic             busy,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] overrun_cnt
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_CLS  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       cls_q, cls_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             valid_q, valid_d;
    logic [1:0]       ccls_q, ccls_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;

    logic tmo_term;
    logic chk_ok;
    logic err_inc;
    logic pass;
    logic ovr_inc;

    assign tmo_term = (tmo_q == TMO_LAST);
    assign chk_ok   = (RxData == ~cls_q) &&
                      ({24'd0, cls_q} < 32'(NUM_CLASSES));

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        tmo_d   = tmo_q;
        err_inc = 1'b0;
        pass    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (ack && RxData == HEADER) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (ack) begin
                    cls_d   = RxData;
                    state_d = ST_CLS;
                    tmo_d   = '0;
                end else if (tmo_term) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CLS: begin
                if (ack) begin
                    tmo_d = '0;
                    if (chk_ok) begin
                        pass    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_inc = 1'b1;
                        // a header in the check slot restarts a frame
                        state_d = (RxData == HEADER) ? ST_HDR : ST_IDLE;
                    end
                end else if (tmo_term) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ccls_d  = ccls_q;
        ovr_inc = 1'b0;
        if (pass) begin
            if (valid_q && !cmd_ready) begin
                ovr_inc = 1'b1;
            end else begin
                valid_d = 1'b1;
                ccls_d  = cls_q[1:0];
            end
        end else if (valid_q && cmd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        ovr_d = ovr_q;
        if (err_inc && err_q != '1) begin
            err_d = err_q + CNT_W'(1);
        end
        if (ovr_inc && ovr_q != '1) begin
            ovr_d = ovr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            ccls_q  <= '0;
            err_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            ccls_q  <= ccls_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign cmd_valid     = valid_q;
    assign cmd_class     = ccls_q;
    assign frame_err_cnt = err_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: directed scenarios plus
// a randomized byte stream checked against a frame-level model.
module tb_uart_cmd_framer;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int NC = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] RxData = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_class;
    logic       busy;
    logic [7:0] frame_err_cnt;
    logic [7:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_frm[$];
    int         m_since = 0;
    logic       m_valid = 1'b0;
    logic [1:0] m_class = 2'd0;
    int         m_err = 0;
    int         m_ovr = 0;

    uart_cmd_framer #(
        .HEADER(HDR),
        .NUM_CLASSES(NC),
        .TIMEOUT_CYC(TMO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ack(ack),
        .RxData(RxData),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_class(cmd_class),
        .busy(busy),
        .frame_err_cnt(frame_err_cnt),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Frame-level reference: bytes collected so far and idle time since last byte.
    task automatic model_update();
        logic       deliver;
        logic [7:0] c;
        logic [7:0] inv;
        deliver = 1'b0;
        c = 8'h00;
        if (rst) begin
            m_frm.delete();
            m_since = 0;
            m_valid = 1'b0;
            m_class = 2'd0;
            m_err = 0;
            m_ovr = 0;
            return;
        end
        if (ack) begin
            m_since = 0;
            if (m_frm.size() == 0) begin
                if (RxData == HDR) m_frm.push_back(RxData);
            end else if (m_frm.size() == 1) begin
                m_frm.push_back(RxData);
            end else begin
                c = m_frm[1];
                inv = ~c;
                m_frm.delete();
                if (RxData == inv && int'(c) < NC) begin
                    deliver = 1'b1;
                end else begin
                    if (m_err < 255) m_err++;
                    if (RxData == HDR) m_frm.push_back(RxData);
                end
            end
        end else if (m_frm.size() != 0) begin
            if (m_since == TMO - 1) begin
                if (m_err < 255) m_err++;
                m_frm.delete();
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        if (deliver) begin
            if (m_valid && !cmd_ready) begin
                if (m_ovr < 255) m_ovr++;
            end else begin
                m_valid = 1'b1;
                m_class = c[1:0];
            end
        end else if (m_valid && cmd_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic a, input logic [7:0] d, input logic r);
        ack = a;
        RxData = d;
        cmd_ready = r;
        @(posedge clk);
        model_update();
        #1;
        ack = 1'b0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r);
    endtask

    task automatic send(input logic [7:0] d, input int gap, input logic r);
        step(1'b1, d, r);
        idle(gap, r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cmd_valid !== 1'b0 || cmd_class !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got v=%b c=%0d b=%b exp 0 0 0",
                     cmd_valid, cmd_class, busy);
        end
        checks++;
        if (frame_err_cnt !== 8'd0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got e=%0d o=%0d exp 0 0",
                     frame_err_cnt, overrun_cnt);
        end
    endtask

    task automatic test_clean();
        do_reset();
        send(HDR, 9, 1'b0);
        send(8'h02, 9, 1'b0);
        step(1'b1, 8'hFD, 1'b0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_class !== 2'd2) begin
            errors++;
            $display("FAIL clean_cmd got v=%b c=%0d exp 1 2", cmd_valid, cmd_class);
        end
        checks++;
        if (frame_err_cnt !== 8'd0 || overrun_cnt !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_cnt got e=%0d o=%0d b=%b exp 0 0 0",
                     frame_err_cnt, overrun_cnt, busy);
        end
        idle(3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0 || cmd_class !== 2'd2) begin
            errors++;
            $display("FAIL clean_pop got v=%b c=%0d exp 0 2", cmd_valid, cmd_class);
        end
    endtask

    task automatic test_resync();
        do_reset();
        send(HDR, 2, 1'b0);
        send(8'h01, 2, 1'b0);
        send(HDR, 2, 1'b0);
        checks++;
        if (frame_err_cnt !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resync_err got e=%0d b=%b exp 1 1", frame_err_cnt, busy);
        end
        send(8'h03, 2, 1'b0);
        step(1'b1, 8'hFC, 1'b0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_class !== 2'd3 || frame_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL resync_cmd got v=%b c=%0d e=%0d exp 1 3 1",
                     cmd_valid, cmd_class, frame_err_cnt);
        end
    endtask

    task automatic test_bad_class();
        do_reset();
        send(HDR, 1, 1'b0);
        send(8'h05, 1, 1'b0);
        send(8'hFA, 1, 1'b0);
        checks++;
        if (frame_err_cnt !== 8'd1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL badcls got e=%0d v=%b exp 1 0", frame_err_cnt, cmd_valid);
        end
        send(8'h00, 1, 1'b0);
        send(8'h7F, 1, 1'b0);
        checks++;
        if (frame_err_cnt !== 8'd1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray got e=%0d b=%b v=%b exp 1 0 0",
                     frame_err_cnt, busy, cmd_valid);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(HDR, 1, 1'b0);
        send(8'h01, TMO - 1, 1'b0);
        checks++;
        if (busy !== 1'b1 || frame_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL tmo_edge got b=%b e=%0d exp 1 0", busy, frame_err_cnt);
        end
        idle(1, 1'b0);
        checks++;
        if (busy !== 1'b0 || frame_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL tmo_hit got b=%b e=%0d exp 0 1", busy, frame_err_cnt);
        end
        do_reset();
        send(HDR, 1, 1'b0);
        send(8'h01, TMO - 1, 1'b0);
        step(1'b1, 8'hFE, 1'b0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_class !== 2'd1 || frame_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL tmo_ackwin got v=%b c=%0d e=%0d exp 1 1 0",
                     cmd_valid, cmd_class, frame_err_cnt);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send(HDR, 1, 1'b0);
        send(8'h01, 1, 1'b0);
        send(8'hFE, 1, 1'b0);
        send(HDR, 1, 1'b0);
        send(8'h02, 1, 1'b0);
        step(1'b1, 8'hFD, 1'b0);
        checks++;
        if (overrun_cnt !== 8'd1 || cmd_valid !== 1'b1 || cmd_class !== 2'd1) begin
            errors++;
            $display("FAIL ovr_drop got o=%0d v=%b c=%0d exp 1 1 1",
                     overrun_cnt, cmd_valid, cmd_class);
        end
        send(HDR, 1, 1'b0);
        send(8'h02, 1, 1'b0);
        step(1'b1, 8'hFD, 1'b1);
        checks++;
        if (overrun_cnt !== 8'd1 || cmd_valid !== 1'b1 || cmd_class !== 2'd2) begin
            errors++;
            $display("FAIL ovr_reload got o=%0d v=%b c=%0d exp 1 1 2",
                     overrun_cnt, cmd_valid, cmd_class);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pop got v=%b exp 0", cmd_valid);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send(HDR, 1, 1'b0);
        send(8'h09, 1, 1'b0);
        send(8'hF6, 1, 1'b0);
        send(HDR, 1, 1'b0);
        do_reset();
        checks++;
        if (busy !== 1'b0 || frame_err_cnt !== 8'd0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid got b=%b e=%0d o=%0d exp 0 0 0",
                     busy, frame_err_cnt, overrun_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(HDR, 0, 1'b0);
            send(8'h01, 0, 1'b0);
            send(8'h00, 0, 1'b0);
            if (i == 253) begin
                checks++;
                if (frame_err_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_254 got %0d exp 254", frame_err_cnt);
                end
            end
        end
        checks++;
        if (frame_err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_255 got %0d exp 255", frame_err_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] last;
        logic [7:0] b;
        int gap;
        int sel;
        last = 8'h00;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) b = HDR;
            else if (sel < 7) b = ~last;
            else if (sel < 9) b = 8'($urandom_range(0, 5));
            else b = 8'($urandom);
            last = b;
            if ($urandom_range(0, 9) == 0) gap = $urandom_range(TMO - 2, TMO + 2);
            else gap = $urandom_range(0, 3);
            for (int g = 0; g <= gap; g++) begin
                step(g == 0, b, 1'($urandom_range(0, 2) == 0));
                checks++;
                if (cmd_valid !== m_valid || cmd_class !== m_class ||
                    busy !== (m_frm.size() != 0) ||
                    frame_err_cnt !== 8'(m_err) || overrun_cnt !== 8'(m_ovr)) begin
                    errors++;
                    $display("FAIL rand got v=%b c=%0d b=%b e=%0d o=%0d exp %b %0d %b %0d %0d",
                             cmd_valid, cmd_class, busy, frame_err_cnt, overrun_cnt,
                             m_valid, m_class, m_frm.size() != 0, m_err, m_ovr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_resync();
        test_bad_class();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
